dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder at the far end of the core's load/store interface: accepts one request at a time from the MEM stage, performs RV32I byte/half/word stores and sign/zero-extended loads, and returns a registered response after a configurable wait.
- Used as on-chip data RAM and as the bench slave for the 5-stage core.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned).
- WAIT_CYCLES, 0, extra cycles between acceptance and response (0..15).

Ports:
- clk  in  1  clock
- clk_en  in  1  clock enable; low freezes all state
- rst_n  in  1  asynchronous reset, active low
- req_i  in  1  request valid
- we_i  in  1  1 = store, 0 = load
- addr_i  in  32  byte address
- funct3_i  in  3  RV32I size code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- wdata_i  in  32  store data, LSB-justified
- gnt_o  out  1  request accepted this cycle (combinational)
- rvalid_o  out  1  response valid, one-cycle pulse
- rdata_o  out  32  load result, extended; 0 for stores/errors
- err_o  out  1  error flag, valid with rvalid_o

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous, active low. Reset: state IDLE, rvalid_o=0, rdata_o=0, err_o=0, wait counter=0. Memory array not reset.
- clk_en=0: no state, counter, memory or output register changes; gnt_o forced 0.
- States: IDLE, WAIT, RESP.
- gnt_o = clk_en & (state==IDLE | state==RESP). Acceptance = req_i & gnt_o at a rising edge.
- On acceptance: decode range/alignment/funct3. Store with no error writes the enabled lanes at that edge. Load reads the word at that edge, then lane-selects and extends into a holding register. Error/write response data = 0.
- Transition after acceptance: WAIT_CYCLES=0 -> RESP; otherwise WAIT with counter=WAIT_CYCLES-1.
- WAIT: counter decrements each enabled edge; at 0 -> RESP.
- RESP: rvalid_o=1 with rdata_o/err_o from the holding register for exactly one enabled cycle. Next state: IDLE, or the WAIT/RESP path for a same-cycle new acceptance (back-to-back).
- Latency: response is visible in cycle N+1+WAIT_CYCLES for acceptance at edge N. Back-to-back throughput at WAIT_CYCLES=0 is one request per cycle.
- Load after store to the same word observes the new data (write committed at the earlier edge).
- Lanes:
  - B/BU use addr[1:0]; H/HU use addr[1].
  - B and H sign-extend; BU and HU zero-extend.
  - SB writes wdata_i[7:0] into the selected byte; SH writes wdata_i[15:0] into the selected half.
- Out of range (addr < BASE_ADDR or >= BASE_ADDR+4*DEPTH_WORDS): no write, rdata 0, err_o=1.
- Illegal funct3 (011, 110, 111; also 100/101 with we_i=1): no write, err_o=1.
- Reset mid-operation: pending response is dropped (no rvalid_o); a store already committed remains.
- rvalid_o, rdata_o and err_o are registered outputs.

Optional Feature:
- Macro DMEM_MISALIGN_ERR_EN.
- Defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, yields err_o=1, no write, rdata 0.
- Undefined: misaligned accesses are silently aligned; offending low address bits are forced to 0 (H: bit0; W: bits1:0) and the access completes with err_o=0.

Test Plan:
- WAIT_CYCLES=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> load response next cycle after accept, rdata_o=0xDEADBEEF, err_o=0.
- SB 0x80 @0x11, then LB @0x11 -> rdata_o=0xFFFFFF80; LBU @0x11 -> 0x00000080; LHU @0x10 -> 0x000080EF.
- WAIT_CYCLES=3: LW accepted at edge N -> rvalid_o only in cycle N+4, gnt_o=0 for cycles N+1..N+3.
- LW @ BASE_ADDR+4*DEPTH_WORDS -> rvalid_o=1, err_o=1, rdata_o=0. SW there -> word 0 unchanged.
- LH @0x13: with DMEM_MISALIGN_ERR_EN -> err_o=1, rdata_o=0; without -> half @0x12 returned, err_o=0.
- Hold clk_en=0 for 5 cycles during WAIT -> no progress, gnt_o=0. Assert rst_n=0 in WAIT -> rvalid_o stays 0, state IDLE after release.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory slave for the core's MEM stage.
// Performs RV32I byte/half/word stores and sign/zero-extended loads and returns
// a registered response WAIT_CYCLES cycles after the response slot.
// Optional build macro: DMEM_MISALIGN_ERR_EN (flag misaligned H/W accesses
// as errors instead of silently aligning them).
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        clk_en,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hold_data_q;
    logic        hold_err_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic [31:0]   offset;
    logic [AW-1:0] widx;
    logic          in_range;
    logic          f3_ok;
    logic          misalign;
    logic          acc_err;
    logic [31:0]   rword;
    logic [7:0]    lbyte;
    logic [15:0]   lhalf;
    logic [31:0]   ldata;
    logic [31:0]   resp_data_d;
    logic          resp_err_d;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;

    assign gnt_o    = clk_en & ((state_q == S_IDLE) | (state_q == S_RESP));
    assign accept   = req_i & gnt_o;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    // Request decode: range, funct3 legality, alignment, load lane extract, store lanes
    always_comb begin
        offset   = addr_i - BASE_ADDR;
        widx     = offset[AW+1:2];
        in_range = (addr_i >= BASE_ADDR) && (offset < 32'(4 * DEPTH_WORDS));

        case (funct3_i)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !we_i;
            default:                f3_ok = 1'b0;
        endcase

`ifdef DMEM_MISALIGN_ERR_EN
        case (funct3_i[1:0])
            2'b01:   misalign = addr_i[0];
            2'b10:   misalign = (addr_i[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
`else
        // Misaligned H/W accesses fall through: half lanes use addr[1] only and
        // words use the word index only, which forces the low bits to zero.
        misalign = 1'b0;
`endif

        acc_err = !in_range || !f3_ok || misalign;

        rword = mem_q[widx];
        case (addr_i[1:0])
            2'b00:   lbyte = rword[7:0];
            2'b01:   lbyte = rword[15:8];
            2'b10:   lbyte = rword[23:16];
            default: lbyte = rword[31:24];
        endcase
        lhalf = addr_i[1] ? rword[31:16] : rword[15:0];

        case (funct3_i)
            3'b000:  ldata = {{24{lbyte[7]}}, lbyte};
            3'b001:  ldata = {{16{lhalf[15]}}, lhalf};
            3'b100:  ldata = {24'h0, lbyte};
            3'b101:  ldata = {16'h0, lhalf};
            default: ldata = rword;
        endcase

        resp_data_d = (we_i || acc_err) ? '0 : ldata;
        resp_err_d  = acc_err;

        case (funct3_i[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << addr_i[1:0];
                wr_data = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                wr_be   = addr_i[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_i[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = wdata_i;
            end
        endcase
    end

    // Storage array: byte-lane writes committed at the accepting edge, never reset
    always_ff @(posedge clk) begin
        if (accept && we_i && !acc_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[widx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered response outputs; outputs read zero outside RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else if (clk_en) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE, S_RESP: begin
                    if (req_i) begin
                        if (WAIT_CYCLES == 0) begin
                            state_q  <= S_RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= resp_data_d;
                            err_q    <= resp_err_d;
                        end else begin
                            state_q     <= S_WAIT;
                            cnt_q       <= WAIT_INIT;
                            hold_data_q <= resp_data_d;
                            hold_err_q  <= resp_err_d;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= S_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= hold_data_q;
                        err_q    <= hold_err_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with a zero-wait
// instance (base 0, 1024 words) and a three-wait instance (base 0x2000, 256 words).
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en0 = 1'b1;
    logic        clk_en3 = 1'b1;
    logic        req0 = 1'b0;
    logic        req3 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] wdata = '0;

    logic        gnt0, rvalid0, err0;
    logic [31:0] rdata0;
    logic        gnt3, rvalid3, err3;
    logic [31:0] rdata3;

    int total = 0;
    int bad = 0;

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (32'h0000_0000),
        .WAIT_CYCLES(0)
    ) u_dut0 (
        .clk     (clk),
        .clk_en  (clk_en0),
        .rst_n   (rst_n),
        .req_i   (req0),
        .we_i    (we),
        .addr_i  (addr),
        .funct3_i(f3),
        .wdata_i (wdata),
        .gnt_o   (gnt0),
        .rvalid_o(rvalid0),
        .rdata_o (rdata0),
        .err_o   (err0)
    );

    dmem_responder #(
        .DEPTH_WORDS(256),
        .BASE_ADDR  (32'h0000_2000),
        .WAIT_CYCLES(3)
    ) u_dut3 (
        .clk     (clk),
        .clk_en  (clk_en3),
        .rst_n   (rst_n),
        .req_i   (req3),
        .we_i    (we),
        .addr_i  (addr),
        .funct3_i(f3),
        .wdata_i (wdata),
        .gnt_o   (gnt3),
        .rvalid_o(rvalid3),
        .rdata_o (rdata3),
        .err_o   (err3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero-wait transaction: response must be visible right after the accepting edge.
    task automatic txn0(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                        input string tag);
        @(negedge clk);
        we = w; f3 = f; addr = a; wdata = wd; req0 = 1'b1;
        #1 chk({tag, ":gnt"}, {31'b0, gnt0}, 32'd1);
        @(posedge clk);
        #1 req0 = 1'b0;
        chk({tag, ":rvalid"}, {31'b0, rvalid0}, 32'd1);
        chk({tag, ":rdata"}, rdata0, ed);
        chk({tag, ":err"}, {31'b0, err0}, {31'b0, ee});
    endtask

    // Three-wait transaction: no grant and no response for three cycles, then response.
    task automatic txn3(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                        input string tag);
        @(negedge clk);
        we = w; f3 = f; addr = a; wdata = wd; req3 = 1'b1;
        #1 chk({tag, ":gnt"}, {31'b0, gnt3}, 32'd1);
        @(posedge clk);
        #1 req3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, ":wait_rvalid"}, {31'b0, rvalid3}, 32'd0);
            chk({tag, ":wait_gnt"}, {31'b0, gnt3}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk({tag, ":rvalid"}, {31'b0, rvalid3}, 32'd1);
        chk({tag, ":rdata"}, rdata3, ed);
        chk({tag, ":err"}, {31'b0, err3}, {31'b0, ee});
        chk({tag, ":resp_gnt"}, {31'b0, gnt3}, 32'd1);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_err0", {31'b0, err0}, 32'd0);
        chk("rst_gnt0", {31'b0, gnt0}, 32'd1);
        chk("rst_rvalid3", {31'b0, rvalid3}, 32'd0);
        rst_n = 1'b1;

        // Zero-wait instance: stores, loads, lanes, extension, back-to-back
        txn0(1'b1, 3'b010, 32'h0000_0000, 32'h0BAD_F00D, 32'h0, 1'b0, "sw0");
        txn0(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw10");
        txn0(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw10");
        txn0(1'b1, 3'b000, 32'h0000_0011, 32'h1234_5680, 32'h0, 1'b0, "sb11");
        txn0(1'b0, 3'b000, 32'h0000_0011, 32'h0, 32'hFFFF_FF80, 1'b0, "lb11");
        txn0(1'b0, 3'b100, 32'h0000_0011, 32'h0, 32'h0000_0080, 1'b0, "lbu11");
        txn0(1'b0, 3'b101, 32'h0000_0010, 32'h0, 32'h0000_80EF, 1'b0, "lhu10");
        txn0(1'b0, 3'b001, 32'h0000_0012, 32'h0, 32'hFFFF_DEAD, 1'b0, "lh12");
        txn0(1'b1, 3'b001, 32'h0000_0012, 32'hFFFF_7654, 32'h0, 1'b0, "sh12");
        txn0(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h7654_80EF, 1'b0, "lw10b");
        txn0(1'b0, 3'b000, 32'h0000_0013, 32'h0, 32'h0000_0076, 1'b0, "lb13");
        @(posedge clk);
        #1 chk("pulse_rvalid0", {31'b0, rvalid0}, 32'd0);
        chk("pulse_rdata0", rdata0, 32'd0);

        // Misaligned accesses
        txn0(1'b0, 3'b001, 32'h0000_0013, 32'h0, MIS ? 32'h0 : 32'h0000_7654, MIS, "lh13_mis");
        txn0(1'b0, 3'b010, 32'h0000_0012, 32'h0, MIS ? 32'h0 : 32'h7654_80EF, MIS, "lw12_mis");
        txn0(1'b1, 3'b010, 32'h0000_0014, 32'h1111_1111, 32'h0, 1'b0, "sw14");
        txn0(1'b1, 3'b010, 32'h0000_0016, 32'hCAFE_F00D, 32'h0, MIS, "sw16_mis");
        txn0(1'b0, 3'b010, 32'h0000_0014, 32'h0, MIS ? 32'h1111_1111 : 32'hCAFE_F00D, 1'b0, "lw14");

        // Illegal funct3
        txn0(1'b0, 3'b011, 32'h0000_0010, 32'h0, 32'h0, 1'b1, "ld_f3_011");
        txn0(1'b0, 3'b110, 32'h0000_0010, 32'h0, 32'h0, 1'b1, "ld_f3_110");
        txn0(1'b1, 3'b100, 32'h0000_0010, 32'h0, 32'h0, 1'b1, "st_f3_100");
        txn0(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h7654_80EF, 1'b0, "lw10_kept");

        // Out of range (0x1000 would alias word 0 if the range check were missing)
        txn0(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h0, 1'b1, "lw_oor");
        txn0(1'b1, 3'b010, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0, 1'b1, "sw_oor");
        txn0(1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'h0BAD_F00D, 1'b0, "lw0_kept");

        // Three-wait instance with non-zero base
        txn3(1'b1, 3'b010, 32'h0000_2004, 32'hA5A5_5A5A, 32'h0, 1'b0, "w3_sw");
        @(posedge clk);
        #1 chk("w3_pulse_rvalid", {31'b0, rvalid3}, 32'd0);
        txn3(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hA5A5_5A5A, 1'b0, "w3_lw");
        txn3(1'b0, 3'b100, 32'h0000_2007, 32'h0, 32'h0000_00A5, 1'b0, "w3_lbu");
        txn3(1'b0, 3'b010, 32'h0000_1FFC, 32'h0, 32'h0, 1'b1, "w3_below");
        txn3(1'b0, 3'b010, 32'h0000_2400, 32'h0, 32'h0, 1'b1, "w3_above");

        // Clock-enable freeze during WAIT
        @(negedge clk);
        we = 1'b0; f3 = 3'b010; addr = 32'h0000_2004; req3 = 1'b1;
        @(posedge clk);
        #1 req3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clk_en3 = 1'b0;
        #1 chk("frz_gnt", {31'b0, gnt3}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk("frz_rvalid", {31'b0, rvalid3}, 32'd0);
            chk("frz_gnt_hold", {31'b0, gnt3}, 32'd0);
        end
        @(negedge clk);
        clk_en3 = 1'b1;
        @(posedge clk);
        #1 chk("frz_resume_rvalid", {31'b0, rvalid3}, 32'd0);
        @(posedge clk);
        #1 chk("frz_done_rvalid", {31'b0, rvalid3}, 32'd1);
        chk("frz_done_rdata", rdata3, 32'hA5A5_5A5A);

        // Reset while in WAIT: response dropped, committed store survives
        @(negedge clk);
        we = 1'b0; f3 = 3'b010; addr = 32'h0000_2004; req3 = 1'b1;
        @(posedge clk);
        #1 req3 = 1'b0;
        chk("rw_gnt_wait", {31'b0, gnt3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rw_rvalid", {31'b0, rvalid3}, 32'd0);
        chk("rw_gnt_idle", {31'b0, gnt3}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk("rw_no_resp", {31'b0, rvalid3}, 32'd0);
        end
        txn3(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hA5A5_5A5A, 1'b0, "rw_lw3");
        txn0(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h7654_80EF, 1'b0, "rw_lw0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
